// File: rtl/string_bit_serializer_if.sv
// Load and serial-bit handshake bundle for string_bit_serializer.
// master: message source plus downstream bit sink; slave: the serializer.
interface string_bit_serializer_if #(
    parameter int unsigned CHARS  = 64,
    parameter int unsigned CHAR_W = 8
);
    localparam int unsigned CNT_W = $clog2(CHARS + 1);

    logic                    load_valid;
    logic                    load_ready;
    logic [CHARS*CHAR_W-1:0] string_in;
    logic [CNT_W-1:0]        char_count;
    logic                    bit_out;
    logic                    bit_valid;
    logic                    bit_ready;
    logic [CNT_W-1:0]        char_index;
    logic                    busy;
    logic                    done;

    modport master (
        output load_valid, string_in, char_count, bit_ready,
        input  load_ready, bit_out, bit_valid, char_index, busy, done
    );

    modport slave (
        input  load_valid, string_in, char_count, bit_ready,
        output load_ready, bit_out, bit_valid, char_index, busy, done
    );
endinterface

// File: rtl/string_bit_serializer.sv
// Buffers a packed string and shifts each character's code out one bit per valid/ready transfer.
// Define STRING_SER_PARITY_EN to append an even-parity bit after every character.
module string_bit_serializer #(
    parameter int unsigned CHARS     = 64,
    parameter int unsigned CHAR_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    string_bit_serializer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CHARS + 1);
    localparam int unsigned BIT_W = $clog2(CHAR_W + 1);
    localparam int unsigned BUF_W = CHARS * CHAR_W;
`ifdef STRING_SER_PARITY_EN
    localparam int unsigned LAST_SLOT = CHAR_W;
`else
    localparam int unsigned LAST_SLOT = CHAR_W - 1;
`endif

    typedef enum logic [1:0] {StIdle, StSend, StFinish} state_e;

    state_e            state_q, state_d;
    logic [BUF_W-1:0]  buf_q;
    logic [CNT_W-1:0]  cnt_q, idx_q, load_cnt;
    logic [BIT_W-1:0]  slot_q;
    logic              load_fire, xfer, last_slot, last_char;
    logic [CHAR_W-1:0] cur_char, msb_shift, lsb_shift;
    logic              data_bit;

    assign load_fire = (state_q == StIdle) && bus.load_valid;
    assign xfer      = (state_q == StSend) && bus.bit_ready;
    assign last_slot = (slot_q == BIT_W'(LAST_SLOT));
    assign last_char = (idx_q == cnt_q);
    assign load_cnt  = (bus.char_count > CNT_W'(CHARS)) ? CNT_W'(CHARS) : bus.char_count;

    // The character being sent always sits at the top of the buffer.
    assign cur_char  = buf_q[BUF_W-1 -: CHAR_W];
    assign msb_shift = cur_char << slot_q;
    assign lsb_shift = cur_char >> slot_q;

    always_comb begin
        data_bit = MSB_FIRST ? msb_shift[CHAR_W-1] : lsb_shift[0];
`ifdef STRING_SER_PARITY_EN
        if (last_slot) data_bit = ^cur_char;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (load_fire) state_d = (load_cnt == '0) ? StFinish : StSend;
            StSend:   if (xfer && last_slot && last_char) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.bit_out    = 1'b0;
        unique case (state_q)
            StIdle:   bus.load_ready = 1'b1;
            StSend: begin
                bus.bit_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.bit_out   = data_bit;
            end
            StFinish: bus.done = 1'b1;
            default:  ;
        endcase
    end

    assign bus.char_index = idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            slot_q <= '0;
        end else if (load_fire) begin
            buf_q  <= bus.string_in;
            cnt_q  <= load_cnt;
            idx_q  <= (load_cnt == '0) ? CNT_W'(0) : CNT_W'(1);
            slot_q <= '0;
        end else if (xfer) begin
            if (last_slot) begin
                slot_q <= '0;
                buf_q  <= buf_q << CHAR_W;
                // Index drops to 0 after the final character instead of running past the count.
                idx_q  <= last_char ? CNT_W'(0) : idx_q + CNT_W'(1);
            end else begin
                slot_q <= slot_q + BIT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_string_bit_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer share stimulus and are checked
// bit by bit against a per-character model plus hand-computed message words.
module tb_string_bit_serializer;
    localparam int unsigned CHARS  = 64;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned W      = CHARS * CHAR_W;
`ifdef STRING_SER_PARITY_EN
    localparam int SLOTS = CHAR_W + 1;
`else
    localparam int SLOTS = CHAR_W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] string_in = '0;
    logic [6:0]   char_count = '0;
    logic         bit_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    string_bit_serializer_if #(.CHARS(CHARS), .CHAR_W(CHAR_W)) if_m ();
    string_bit_serializer_if #(.CHARS(CHARS), .CHAR_W(CHAR_W)) if_l ();

    assign if_m.load_valid = load_valid;
    assign if_m.string_in  = string_in;
    assign if_m.char_count = char_count;
    assign if_m.bit_ready  = bit_ready;
    assign if_l.load_valid = load_valid;
    assign if_l.string_in  = string_in;
    assign if_l.char_count = char_count;
    assign if_l.bit_ready  = bit_ready;

    string_bit_serializer #(.CHARS(CHARS), .CHAR_W(CHAR_W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(if_m.slave)
    );
    string_bit_serializer #(.CHARS(CHARS), .CHAR_W(CHAR_W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(if_l.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_ready);
        check({tag, " load_ready"}, 32'(if_m.load_ready), 32'(exp_ready));
        check({tag, " bit_valid"},  32'(if_m.bit_valid), 0);
        check({tag, " bit_out"},    32'(if_m.bit_out), 0);
        check({tag, " busy"},       32'(if_m.busy), 0);
        check({tag, " char_index"}, 32'(if_m.char_index), 0);
        check({tag, " lsb valid"},  32'(if_l.bit_valid), 0);
    endtask

    // Loads a message, consumes it and returns the last 32 serial bits of each DUT.
    task automatic send_msg(input string tag, input logic [W-1:0] s, input int cnt,
                            input bit toggle, output logic [31:0] wm, output logic [31:0] wl);
        int n_chars, total, got, cyc, c, j, exp_cyc;
        logic [7:0] ch;
        logic em, el;
        n_chars = (cnt > CHARS) ? CHARS : cnt;
        total   = n_chars * SLOTS;
        wm = '0;
        wl = '0;
        @(posedge clk); #1;
        string_in  = s;
        char_count = 7'(cnt);
        load_valid = 1'b1;
        bit_ready  = 1'b1;
        @(negedge clk);
        check({tag, " load_ready"}, 32'(if_m.load_ready), 1);
        @(posedge clk); #1;
        string_in = ~s;  // must not disturb the buffered message; load_valid stays high
        got = 0;
        cyc = 0;
        while (got < total && cyc < 4 * total + 10) begin
            bit_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            c  = got / SLOTS;
            j  = got % SLOTS;
            ch = s[W-1-8*c -: 8];
            em = (j < CHAR_W) ? ch[7-j] : ^ch;
            el = (j < CHAR_W) ? ch[j] : ^ch;
            check({tag, " valid"},     32'(if_m.bit_valid), 1);
            check({tag, " busy"},      32'(if_l.busy), 1);
            check({tag, " msb bit"},   32'(if_m.bit_out), 32'(em));
            check({tag, " lsb bit"},   32'(if_l.bit_out), 32'(el));
            check({tag, " index"},     32'(if_m.char_index), 32'(c + 1));
            check({tag, " lsb index"}, 32'(if_l.char_index), 32'(c + 1));
            @(posedge clk); #1;
            if (bit_ready) begin
                wm = {wm[30:0], em};
                wl = {wl[30:0], el};
                got++;
            end
            cyc++;
        end
        load_valid = 1'b0;
        bit_ready  = 1'b1;
        exp_cyc = (total == 0) ? 0 : (toggle ? 2 * total - 1 : total);
        check({tag, " transfers"}, 32'(got), 32'(total));
        check({tag, " cycles"},    32'(cyc), 32'(exp_cyc));
        @(negedge clk);
        check({tag, " done"},       32'(if_m.done), 1);
        check({tag, " lsb done"},   32'(if_l.done), 1);
        check({tag, " fin valid"},  32'(if_m.bit_valid), 0);
        check({tag, " fin busy"},   32'(if_m.busy), 0);
        check({tag, " fin index"},  32'(if_m.char_index), 0);
        check({tag, " fin ready"},  32'(if_m.load_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " done low"},   32'(if_m.done), 0);
        check({tag, " ready back"}, 32'(if_m.load_ready), 1);
    endtask

    logic [W-1:0] s;
    logic [31:0]  wm, wl;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in reset", 1'b1);
        check("in reset done", 32'(if_m.done), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // "Hi", bit_ready held high
        s = '0;
        s[W-1 -: 16] = 16'h4869;
        send_msg("hi", s, 2, 1'b0, wm, wl);
`ifdef STRING_SER_PARITY_EN
        check("hi msb word", wm, 32'h0001_20D2);
        check("hi lsb word", wl, 32'h0000_492C);
`else
        check("hi msb word", wm, 32'h0000_4869);
        check("hi lsb word", wl, 32'h0000_1296);
`endif

        // "Hi" with bit_ready toggling
        send_msg("hi toggle", s, 2, 1'b1, wm, wl);
`ifdef STRING_SER_PARITY_EN
        check("toggle msb word", wm, 32'h0001_20D2);
`else
        check("toggle msb word", wm, 32'h0000_4869);
`endif

        // Empty message
        send_msg("empty", s, 0, 1'b0, wm, wl);

        // Count above CHARS clamps to 64 characters
        for (int i = 0; i < CHARS; i++) s[W-1-8*i -: 8] = 8'(i * 7 + 3);
        send_msg("clamp", s, 70, 1'b0, wm, wl);

        // Reset after the 5th bit of "ABC"
        @(posedge clk); #1;
        string_in = '0;
        string_in[W-1 -: 24] = 24'h414243;
        char_count = 7'd3;
        load_valid = 1'b1;
        bit_ready  = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset valid", 32'(if_m.bit_valid), 1);
        check("pre-reset index", 32'(if_m.char_index), 1);
        #1 reset = 1'b1;
        #1;
        check_idle_outputs("async reset", 1'b1);
        check("async reset done", 32'(if_m.done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no done after reset", 32'(if_m.done | if_l.done), 0);
        end

        // "A" after reset
        s = '0;
        s[W-1 -: 8] = 8'h41;
        send_msg("A", s, 1, 1'b0, wm, wl);
`ifdef STRING_SER_PARITY_EN
        check("A msb word", wm, 32'h0000_0082);
        check("A lsb word", wl, 32'h0000_0104);
`else
        check("A msb word", wm, 32'h0000_0041);
        check("A lsb word", wl, 32'h0000_0082);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
